// File: rtl/frame_border_pad_pkg.sv
// -----------------------------------------------------------------------------
// frame_border_pad_pkg
//   Shared definitions for the frame border-insertion stage:
//   - border mode codes (zero / constant / edge replica)
//   - FSM state encoding, also visible on the top-level debug port
//   - small helpers for the border width and for mode normalisation
// -----------------------------------------------------------------------------
package frame_border_pad_pkg;

   // Border modes as sampled from iMode alongside newFrame.
   localparam logic [1:0] PAD_ZERO  = 2'd0;
   localparam logic [1:0] PAD_CONST = 2'd1;
   localparam logic [1:0] PAD_REPL  = 2'd2;

   // Frame sequencing states. IDLE must stay at 0: the debug port reads 0 after reset.
   typedef enum logic [2:0] {
      PAD_IDLE   = 3'd0,
      PAD_TOP    = 3'd1,
      PAD_LEFT   = 3'd2,
      PAD_DATA   = 3'd3,
      PAD_RIGHT  = 3'd4,
      PAD_BOTTOM = 3'd5
   } pad_state_e;

   // Border thickness on each side for an odd kernel.
   function automatic int pad_border(input int kernel_size);
      return (kernel_size - 1) / 2;
   endfunction

   // The unused code 3 behaves like a zero border.
   function automatic logic [1:0] pad_norm_mode(input logic [1:0] mode);
      return (mode == 2'd3) ? PAD_ZERO : mode;
   endfunction

endpackage

// File: rtl/pad_out_reg.sv
// -----------------------------------------------------------------------------
// pad_out_reg
//   One-deep valid/ready register slice carrying a pixel plus three
//   frame-position flags (sof, eol, done).
//
//   Handshake (both sides): a beat transfers on a rising clk edge where
//   valid && ready. A producer holding valid may not change its payload until
//   the transfer. Here in_ready = !out_valid || out_ready, so the slice loads
//   whenever it is empty or its current beat is leaving; while
//   out_valid && !out_ready every output holds.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid/in_ready        upstream handshake
//   in_data/sof/eol/done     upstream payload
//   out_valid/out_ready      downstream handshake
//   out_data/sof/eol/done    registered payload (all zero after reset)
// -----------------------------------------------------------------------------
module pad_out_reg #(
   parameter int PW = 24
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   input  logic [PW-1:0] in_data,
   input  logic          in_sof,
   input  logic          in_eol,
   input  logic          in_done,
   output logic          in_ready,
   output logic          out_valid,
   output logic [PW-1:0] out_data,
   output logic          out_sof,
   output logic          out_eol,
   output logic          out_done,
   input  logic          out_ready
);

   logic          valid_q, valid_d;
   logic [PW-1:0] data_q,  data_d;
   logic          sof_q,   sof_d;
   logic          eol_q,   eol_d;
   logic          done_q,  done_d;

   assign in_ready = !valid_q || out_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sof_d   = sof_q;
      eol_d   = eol_q;
      done_d  = done_q;
      if (in_ready) begin
         valid_d = in_valid;
         // Payload only moves with a real beat; an empty load keeps the old bits.
         if (in_valid) begin
            data_d = in_data;
            sof_d  = in_sof;
            eol_d  = in_eol;
            done_d = in_done;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         done_q  <= done_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sof   = sof_q;
   assign out_eol   = eol_q;
   assign out_done  = done_q;

endmodule

// File: rtl/frame_border_pad.sv
// -----------------------------------------------------------------------------
// frame_border_pad
//   Wraps each WIDTH x HEIGHT raster frame with B = (KERNEL_SIZE-1)/2 border
//   pixels on every side so an NxN filter downstream sees a full neighbourhood
//   at the frame edges. Output frame is (WIDTH+2B) x (HEIGHT+2B), raster order.
//
//   Handshake (both sides): a beat transfers on a rising clk edge where
//   valid && ready; a producer holding valid keeps its payload stable until the
//   transfer. Input is consumed only while emitting the active part of a row;
//   during border beats iReady is low and upstream stalls.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   newFrame         start pulse, honoured only when idle
//   iMode, iConst    border mode and constant, sampled with newFrame
//   iValid/iReady    input pixel handshake, iData in raster order
//   oValid/oReady    output beat handshake, oData padded pixel
//   oSof/oEol/oDone  first beat of frame / last beat of row / last beat of frame
//   oErr             sticky: newFrame arrived while a frame was in progress
//   dbg_state        current sequencing state (pad_state_e encoding)
// -----------------------------------------------------------------------------
module frame_border_pad
   import frame_border_pad_pkg::*;
#(
   parameter int WIDTH       = 1920,
   parameter int HEIGHT      = 1080,
   parameter int KERNEL_SIZE = 7,
   parameter int CHANNELS    = 3,
   parameter int DATA_W      = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         newFrame,
   input  logic [1:0]                   iMode,
   input  logic [CHANNELS*DATA_W-1:0]   iConst,
   input  logic                         iValid,
   input  logic [CHANNELS*DATA_W-1:0]   iData,
   output logic                         iReady,
   output logic                         oValid,
   input  logic                         oReady,
   output logic [CHANNELS*DATA_W-1:0]   oData,
   output logic                         oSof,
   output logic                         oEol,
   output logic                         oDone,
   output logic                         oErr,
   output logic [2:0]                   dbg_state
);

   localparam int PW = CHANNELS * DATA_W;
   localparam int B  = pad_border(KERNEL_SIZE);
   localparam int OW = WIDTH + 2 * B;
   localparam int OH = HEIGHT + 2 * B;
   localparam int XW = $clog2(OW);
   localparam int YW = $clog2(OH);

   // Column / row positions where the sequencing changes segment.
   localparam logic [XW-1:0] X_LEFT_LAST = XW'(B - 1);
   localparam logic [XW-1:0] X_DATA_LAST = XW'(B + WIDTH - 1);
   localparam logic [XW-1:0] X_LAST      = XW'(OW - 1);
   localparam logic [YW-1:0] Y_TOP_LAST  = YW'(B - 1);
   localparam logic [YW-1:0] Y_DATA_LAST = YW'(B + HEIGHT - 1);
   localparam logic [YW-1:0] Y_LAST      = YW'(OH - 1);

   pad_state_e      state_q, state_d;
   logic [XW-1:0]   ox_q,    ox_d;
   logic [YW-1:0]   oy_q,    oy_d;
   logic [1:0]      mode_q,  mode_d;
   logic [PW-1:0]   const_q, const_d;
   logic [PW-1:0]   last_q,  last_d;     // last active pixel of the current row
   logic            err_q,   err_d;

   logic            slice_ready;
   logic            beat_valid;
   logic [PW-1:0]   beat_data;
   logic [PW-1:0]   border;
   logic            beat_sof, beat_eol, beat_done;
   logic            fire;

   // Border value for the current state.
   always_comb begin
      border = '0;
      case (mode_q)
         PAD_CONST: border = const_q;
         PAD_REPL: begin
            case (state_q)
               PAD_LEFT:  border = iData;   // peeked, consumed later in DATA
               PAD_RIGHT: border = last_q;
               default:   border = const_q; // top and bottom rows
            endcase
         end
         default:   border = '0;
      endcase
   end

   // Flags derive from the position of the beat being loaded.
   assign beat_sof  = (ox_q == '0) && (oy_q == '0);
   assign beat_eol  = (ox_q == X_LAST);
   assign beat_done = beat_eol && (oy_q == Y_LAST);

   // Beat source and availability per state.
   always_comb begin
      beat_valid = 1'b0;
      beat_data  = '0;
      case (state_q)
         PAD_TOP, PAD_RIGHT, PAD_BOTTOM: begin
            beat_valid = 1'b1;
            beat_data  = border;
         end
         PAD_LEFT: begin
            // A replicated left edge needs the row's first pixel on the bus.
            beat_valid = (mode_q == PAD_REPL) ? iValid : 1'b1;
            beat_data  = border;
         end
         PAD_DATA: begin
            beat_valid = iValid;
            beat_data  = iData;
         end
         default: begin
            beat_valid = 1'b0;
            beat_data  = '0;
         end
      endcase
   end

   assign fire   = beat_valid && slice_ready;
   assign iReady = (state_q == PAD_DATA) && slice_ready;

   // Next-state, counters and frame parameters.
   always_comb begin
      state_d = state_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      mode_d  = mode_q;
      const_d = const_q;
      last_d  = last_q;
      err_d   = err_q;

      if (newFrame && (state_q != PAD_IDLE)) begin
         err_d = 1'b1;
      end

      if (state_q == PAD_IDLE) begin
         if (newFrame) begin
            state_d = PAD_TOP;
            mode_d  = pad_norm_mode(iMode);
            const_d = iConst;
            ox_d    = '0;
            oy_d    = '0;
         end
      end else if (fire) begin
         if (ox_q == X_LAST) begin
            ox_d = '0;
            oy_d = (oy_q == Y_LAST) ? '0 : oy_q + 1'b1;
         end else begin
            ox_d = ox_q + 1'b1;
         end

         case (state_q)
            PAD_TOP: begin
               if (beat_eol && (oy_q == Y_TOP_LAST)) state_d = PAD_LEFT;
            end
            PAD_LEFT: begin
               if (ox_q == X_LEFT_LAST) state_d = PAD_DATA;
            end
            PAD_DATA: begin
               last_d = iData;
               if (ox_q == X_DATA_LAST) state_d = PAD_RIGHT;
            end
            PAD_RIGHT: begin
               if (beat_eol) state_d = (oy_q == Y_DATA_LAST) ? PAD_BOTTOM : PAD_LEFT;
            end
            PAD_BOTTOM: begin
               if (beat_done) state_d = PAD_IDLE;
            end
            default: state_d = PAD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PAD_IDLE;
         ox_q    <= '0;
         oy_q    <= '0;
         mode_q  <= PAD_ZERO;
         const_q <= '0;
         last_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         mode_q  <= mode_d;
         const_q <= const_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   pad_out_reg #(
      .PW (PW)
   ) u_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (beat_valid && (state_q != PAD_IDLE)),
      .in_data   (beat_data),
      .in_sof    (beat_sof),
      .in_eol    (beat_eol),
      .in_done   (beat_done),
      .in_ready  (slice_ready),
      .out_valid (oValid),
      .out_data  (oData),
      .out_sof   (oSof),
      .out_eol   (oEol),
      .out_done  (oDone),
      .out_ready (oReady)
   );

   assign oErr      = err_q;
   assign dbg_state = state_q;

endmodule
